// File: rtl/spi_main_if.sv
// Byte-level handshake between local logic and the spi_main SPI controller.
// The local logic uses the master modport; spi_main uses the slave modport.
interface spi_main_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       rx_start;
  logic       busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_timeout;

  modport master (
    output tx_data, tx_start, rx_start,
    input  busy, tx_done, rx_data, rx_valid, rx_timeout
  );

  modport slave (
    input  tx_data, tx_start, rx_start,
    output busy, tx_done, rx_data, rx_valid, rx_timeout
  );
endinterface

// File: rtl/spi_main.sv
// SPI main controller for the framed 8-bit protocol ('1' start bit, then 8
// data bits MSB first). mosi is updated and miso sampled on rising sclk; the
// sub works on falling sclk.
// Optional: define SPI_MAIN_STATS_EN to add tx_count/rx_count frame counters.
module spi_main #(
  parameter int CLK_DIV    = 4,
  parameter int RX_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  spi_main_if.slave bus,
  output logic sclk,
  output logic cs,
  output logic mosi,
  input  logic miso
`ifdef SPI_MAIN_STATS_EN
  ,
  output logic [7:0] tx_count,
  output logic [7:0] rx_count
`endif
);
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LEAD, TX_SHIFT, RX_WAIT, RX_SHIFT, TRAIL
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [3:0]        bit_cnt;   // rises seen in the current shift state
  logic [TO_W-1:0]   wait_cnt;  // rises seen in RX_WAIT without a start bit
  logic [7:0]        tx_sr;
  logic [7:0]        shift_in;
  logic              last;      // final rise done; leave on the next fall
  logic              abort;     // receive ended by timeout
  logic              is_tx;
  logic              tick;
  logic              rise;
  logic              fall;

  // Half-period boundary and the sclk edge it produces in shift states.
  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  // Frame sequencer: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      wait_cnt       <= '0;
      tx_sr          <= '0;
      shift_in       <= '0;
      last           <= 1'b0;
      abort          <= 1'b0;
      is_tx          <= 1'b0;
      sclk           <= 1'b0;
      cs             <= 1'b1;
      mosi           <= 1'b0;
      bus.busy       <= 1'b0;
      bus.tx_done    <= 1'b0;
      bus.rx_valid   <= 1'b0;
      bus.rx_timeout <= 1'b0;
      bus.rx_data    <= '0;
`ifdef SPI_MAIN_STATS_EN
      tx_count       <= '0;
      rx_count       <= '0;
`endif
    end else begin
      bus.tx_done    <= 1'b0;
      bus.rx_valid   <= 1'b0;
      bus.rx_timeout <= 1'b0;
      if (state != IDLE)
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

      case (state)
        IDLE: begin
          div_cnt  <= '0;
          bit_cnt  <= '0;
          wait_cnt <= '0;
          last     <= 1'b0;
          abort    <= 1'b0;
          // tx has priority; a simultaneous rx_start is dropped
          if (bus.tx_start) begin
            state    <= LEAD;
            cs       <= 1'b0;
            bus.busy <= 1'b1;
            is_tx    <= 1'b1;
            tx_sr    <= bus.tx_data;
          end else if (bus.rx_start) begin
            state    <= LEAD;
            cs       <= 1'b0;
            bus.busy <= 1'b1;
            is_tx    <= 1'b0;
          end
        end

        LEAD: if (tick) state <= is_tx ? TX_SHIFT : RX_WAIT;

        TX_SHIFT: if (tick) begin
          sclk <= !sclk;
          if (rise) begin
            bit_cnt <= bit_cnt + 4'd1;
            // start bit, 8 data bits, then a low guard period
            if (bit_cnt == 4'd0)
              mosi <= 1'b1;
            else if (bit_cnt <= 4'd8) begin
              mosi  <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end else
              mosi <= 1'b0;
          end else if (bit_cnt == 4'd10)
            state <= TRAIL;
        end

        RX_WAIT: if (tick) begin
          sclk <= !sclk;
          if (rise) begin
            if (miso) begin
              state   <= RX_SHIFT;
              bit_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + TO_W'(1);
              if (wait_cnt == TO_W'(RX_TIMEOUT - 1)) begin
                last  <= 1'b1;
                abort <= 1'b1;
              end
            end
          end else if (last)
            state <= TRAIL;
        end

        RX_SHIFT: if (tick) begin
          sclk <= !sclk;
          if (rise) begin
            shift_in <= {shift_in[6:0], miso};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) last <= 1'b1;
          end else if (last)
            state <= TRAIL;
        end

        TRAIL: if (tick) begin
          state    <= IDLE;
          cs       <= 1'b1;
          mosi     <= 1'b0;
          bus.busy <= 1'b0;
          if (is_tx) begin
            bus.tx_done <= 1'b1;
`ifdef SPI_MAIN_STATS_EN
            tx_count    <= tx_count + 8'd1;
`endif
          end else if (abort)
            bus.rx_timeout <= 1'b1;
          else begin
            bus.rx_valid <= 1'b1;
            bus.rx_data  <= shift_in;
`ifdef SPI_MAIN_STATS_EN
            rx_count     <= rx_count + 8'd1;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_main.sv
// Scoreboard bench for spi_main: a behavioural SPI sub drives miso and
// decodes mosi; stimulus pushes expected frame outcomes, a monitor pops them.
module tb_spi_main;
  localparam int CLK_DIV    = 4;
  localparam int RX_TIMEOUT = 64;
  localparam int TX_LAT     = 1 + CLK_DIV * 22;  // LEAD + 20 shift halves + TRAIL

  typedef struct {
    int         kind;   // 0 tx_done, 1 rx_valid, 2 rx_timeout
    logic [7:0] data;
    int         cyc;    // expected pulse cycle (tx only)
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk, cs, mosi;
  logic miso = 1'b0;
  spi_main_if bus();
`ifdef SPI_MAIN_STATS_EN
  logic [7:0] tx_count, rx_count;
  int m_tx_cnt = 0, m_rx_cnt = 0;
`endif

  spi_main #(.CLK_DIV(CLK_DIV), .RX_TIMEOUT(RX_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
`ifdef SPI_MAIN_STATS_EN
    , .tx_count(tx_count), .rx_count(rx_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];
  logic [7:0] model_rx = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural sub: samples mosi and drives miso on falling sclk.
  logic [7:0] sub_ld_data = 8'h00;
  int         sub_ld_dly  = 0;
  int         sub_ld_seq  = 0;
  int         sub_seen = 0, sub_idx = 0, sub_dly = 0, sub_nb = 0;
  bit         sub_act = 0, sub_in = 0;
  logic [7:0] sub_sr = 8'h00, sub_data_out = 8'h00;
  always @(negedge sclk or posedge cs) begin
    if (cs) begin
      sub_in = 0; sub_act = 0; miso = 1'b0; sub_seen = sub_ld_seq;
    end else begin
      if (!sub_in) begin
        if (mosi) begin sub_in = 1; sub_nb = 0; end
      end else begin
        sub_sr = {sub_sr[6:0], mosi};
        sub_nb++;
        if (sub_nb == 8) begin sub_data_out = sub_sr; sub_in = 0; end
      end
      if (sub_ld_seq != sub_seen) begin
        sub_seen = sub_ld_seq; sub_act = 1; sub_idx = 0; sub_dly = sub_ld_dly;
      end
      if (sub_act) begin
        if (sub_dly > 0) sub_dly--;
        else begin
          miso = (sub_idx == 0) ? 1'b1 : (sub_idx <= 8) ? sub_ld_data[8 - sub_idx] : 1'b0;
          sub_idx++;
          if (sub_idx > 9) sub_act = 0;
        end
      end
    end
  end

  // Monitor: record mosi at every sclk rise, check each completion pulse.
  bit prev_sclk = 0;
  logic rises[$];
  always @(negedge clk) begin
    if (reset) begin
      rises.delete();
      prev_sclk = 0;
    end else begin
      if (sclk && !prev_sclk) rises.push_back(mosi);
      prev_sclk = sclk;
      if (bus.tx_done || bus.rx_valid || bus.rx_timeout) begin
        exp_t e;
        int k;
        int ones;
        k = bus.tx_done ? 0 : bus.rx_valid ? 1 : 2;
        chk("one_pulse", int'(bus.tx_done) + int'(bus.rx_valid) + int'(bus.rx_timeout), 1);
        chk("pulse_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pulse_kind", k, e.kind);
          chk("cs_high_at_pulse", int'(cs), 1);
          chk("busy_low_at_pulse", int'(bus.busy), 0);
          if (e.kind == 0 && k == 0) begin
            chk("tx_done_cycle", cyc, e.cyc);
            chk("tx_rise_count", rises.size(), 10);
            for (int i = 0; i < 10 && i < rises.size(); i++)
              chk($sformatf("tx_mosi_rise%0d", i), int'(rises[i]),
                  (i == 0) ? 1 : (i <= 8) ? int'(e.data[8 - i]) : 0);
            chk("sub_data_out", int'(sub_data_out), int'(e.data));
`ifdef SPI_MAIN_STATS_EN
            m_tx_cnt = (m_tx_cnt + 1) % 256;
            chk("tx_count", int'(tx_count), m_tx_cnt);
`endif
          end else if (e.kind != 0 && k != 0) begin
            ones = 0;
            foreach (rises[i]) ones += int'(rises[i]);
            chk("rx_mosi_low", ones, 0);
            chk("rx_data", int'(bus.rx_data), int'(e.data));
            if (e.kind == 2) chk("timeout_rises", rises.size(), RX_TIMEOUT);
`ifdef SPI_MAIN_STATS_EN
            if (e.kind == 1) m_rx_cnt = (m_rx_cnt + 1) % 256;
            chk("rx_count", int'(rx_count), m_rx_cnt);
`endif
          end
        end
        rises.delete();
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic do_tx(input logic [7:0] d);
    exp_t e;
    @(posedge clk); #1;
    bus.tx_data = d; bus.tx_start = 1'b1;
    e.kind = 0; e.data = d; e.cyc = cyc + TX_LAT;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    wait_drain();
  endtask

  task automatic do_rx(input logic [7:0] d, input int dly, input bit timeout);
    exp_t e;
    @(posedge clk); #1;
    bus.rx_start = 1'b1;
    if (!timeout) model_rx = d;
    e.kind = timeout ? 2 : 1; e.data = model_rx; e.cyc = 0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.rx_start = 1'b0;
    if (!timeout) begin
      sub_ld_data = d; sub_ld_dly = dly; sub_ld_seq++;
    end
    wait_drain();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_tx_done"}, int'(bus.tx_done), 0);
    chk({tag, "_rx_valid"}, int'(bus.rx_valid), 0);
    chk({tag, "_rx_timeout"}, int'(bus.rx_timeout), 0);
    chk({tag, "_rx_data"}, int'(bus.rx_data), 0);
    chk({tag, "_sclk"}, int'(sclk), 0);
    chk({tag, "_cs"}, int'(cs), 1);
    chk({tag, "_mosi"}, int'(mosi), 0);
  endtask

  initial begin
    #(600000);
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_data = 8'h00; bus.tx_start = 1'b0; bus.rx_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // directed frames
    do_tx(8'hA5);
    do_rx(8'h3C, 0, 0);
    do_rx(8'h00, 0, 1);

    // collision: tx wins, later starts mid-frame ignored
    begin
      exp_t e;
      @(posedge clk); #1;
      bus.tx_data = 8'h5A; bus.tx_start = 1'b1; bus.rx_start = 1'b1;
      e.kind = 0; e.data = 8'h5A; e.cyc = cyc + TX_LAT;
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.tx_start = 1'b0; bus.rx_start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("busy_mid_frame", int'(bus.busy), 1);
      bus.tx_data = 8'hFF; bus.tx_start = 1'b1; bus.rx_start = 1'b1;
      @(posedge clk); #1;
      bus.tx_start = 1'b0; bus.rx_start = 1'b0;
      wait_drain();
      repeat (150) @(posedge clk);
    end

    // reset during TX_SHIFT data bit 4
    @(posedge clk); #1;
    bus.tx_data = 8'h99; bus.tx_start = 1'b1;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midreset");
    reset = 1'b0;
    model_rx = 8'h00;
    repeat (120) @(posedge clk);
    do_tx(8'h0F);

    // randomized mix
    for (int n = 0; n < 25; n++) begin
      int sel;
      logic [7:0] d;
      sel = $urandom_range(0, 9);
      d = 8'($urandom);
      if (sel < 5) do_tx(d);
      else if (sel < 9) do_rx(d, $urandom_range(0, 40), 0);
      else do_rx(d, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
